// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive message buffer.
//   - wr_state_e         : write-side framing state (ACCEPT / DISCARD)
//   - TERMINATOR_DEFAULT : default end-of-message byte (line feed)
//   - is_term()          : byte-equals-terminator helper
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } wr_state_e;

  localparam logic [7:0] TERMINATOR_DEFAULT = 8'h0A;

  function automatic logic is_term(input logic [7:0] b, input logic [7:0] term);
    return (b == term);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is presented
//   combinationally on o_Rd_Data whenever o_Empty is low. Storage is not reset;
//   only pointers and the level counter are.
//
// Ports
//   i_Clock     : clock, rising edge
//   i_Reset_N   : synchronous active-low reset
//   i_Push      : write i_Wr_Data (ignored when full)
//   i_Wr_Data   : data to write
//   i_Pop       : discard head entry (ignored when empty)
//   o_Rd_Data   : head entry (don't-care while empty)
//   o_Full      : level == DEPTH
//   o_Empty     : level == 0
//   o_Level     : number of stored entries
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_N,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic                     i_Pop,
  output logic [WIDTH-1:0]         o_Rd_Data,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Level
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok  = i_Push && !o_Full;
    pop_ok   = i_Pop  && !o_Empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // Pointers are AW bits wide and DEPTH is a power of two, so the
    // increment wraps modulo DEPTH on its own.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset_N && push_ok) mem_q[wr_ptr_q] <= i_Wr_Data;
  end

  assign o_Rd_Data = mem_q[rd_ptr_q];
  assign o_Full    = (level_q == LVL_FULL);
  assign o_Empty   = (level_q == '0);
  assign o_Level   = level_q;

endmodule

// File: rtl/uart_rx_msg_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_msg_buffer
//   Buffers bytes from a UART receiver and tracks complete messages (runs of
//   bytes closed by TERMINATOR). When the buffer fills, the rest of the current
//   message is discarded up to its terminator, which is still stored (if room
//   exists) so the consumer sees a truncated but properly closed message.
//
// Ports
//   i_Clock          : clock, rising edge
//   i_Reset_N        : synchronous active-low reset
//   i_Rx_DV          : one-cycle strobe, i_Rx_Byte valid
//   i_Rx_Byte        : received byte
//   i_Rd_En          : pop the head byte
//   i_Clear_Overflow : clear the sticky overflow flag
//   o_Byte_Valid     : head byte present
//   o_Byte           : head byte (first-word-fall-through)
//   o_Last           : head byte is TERMINATOR
//   o_Level          : stored byte count
//   o_Msg_Count      : stored TERMINATOR count
//   o_Full           : buffer full
//   o_Overflow       : sticky, a byte was dropped because the buffer was full
// -----------------------------------------------------------------------------
module uart_rx_msg_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter logic [7:0]  TERMINATOR = TERMINATOR_DEFAULT
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_N,
  input  logic                     i_Rx_DV,
  input  logic [7:0]               i_Rx_Byte,
  input  logic                     i_Rd_En,
  input  logic                     i_Clear_Overflow,
  output logic                     o_Byte_Valid,
  output logic [7:0]               o_Byte,
  output logic                     o_Last,
  output logic [$clog2(DEPTH):0]   o_Level,
  output logic [$clog2(DEPTH):0]   o_Msg_Count,
  output logic                     o_Full,
  output logic                     o_Overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  wr_state_e   state_q, state_d;
  logic        overflow_q, overflow_d;
  logic [AW:0] msg_count_q, msg_count_d;

  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [AW:0] fifo_level;

  logic        push, pop, ovf_event;
  logic        rx_is_term, head_is_term;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_N (i_Reset_N),
    .i_Push    (push),
    .i_Wr_Data (i_Rx_Byte),
    .i_Pop     (pop),
    .o_Rd_Data (fifo_head),
    .o_Full    (fifo_full),
    .o_Empty   (fifo_empty),
    .o_Level   (fifo_level)
  );

  assign rx_is_term   = is_term(i_Rx_Byte, TERMINATOR);
  assign head_is_term = is_term(fifo_head, TERMINATOR);
  assign pop          = i_Rd_En && !fifo_empty;

  // State register
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) state_q <= ST_ACCEPT;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (i_Rx_DV) begin
      case (state_q)
        // A dropped terminator already closes the message, so there is
        // nothing left to discard.
        ST_ACCEPT:  if (fifo_full && !rx_is_term) state_d = ST_DISCARD;
        ST_DISCARD: if (rx_is_term && !fifo_full) state_d = ST_ACCEPT;
        default:    state_d = ST_ACCEPT;
      endcase
    end
  end

  // Output logic: write strobe and overflow event. Fullness is the
  // registered value, so a same-cycle pop never makes room for the write.
  always_comb begin
    push      = 1'b0;
    ovf_event = 1'b0;
    if (i_Rx_DV) begin
      case (state_q)
        ST_ACCEPT: begin
          if (!fifo_full) push      = 1'b1;
          else            ovf_event = 1'b1;
        end
        ST_DISCARD: begin
          if (fifo_full)       ovf_event = 1'b1;
          else if (rx_is_term) push      = 1'b1;
        end
        default: begin
          push      = 1'b0;
          ovf_event = 1'b0;
        end
      endcase
    end
  end

  // Message counter and sticky overflow flag
  always_comb begin
    msg_count_d = msg_count_q;
    case ({push && rx_is_term, pop && head_is_term})
      2'b10:   msg_count_d = msg_count_q + CNT_ONE;
      2'b01:   msg_count_d = msg_count_q - CNT_ONE;
      default: msg_count_d = msg_count_q;
    endcase

    overflow_d = overflow_q;
    if (ovf_event)             overflow_d = 1'b1;
    else if (i_Clear_Overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      msg_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      msg_count_q <= msg_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_Byte_Valid = !fifo_empty;
  assign o_Byte       = fifo_head;
  assign o_Last       = !fifo_empty && head_is_term;
  assign o_Level      = fifo_level;
  assign o_Msg_Count  = msg_count_q;
  assign o_Full       = fifo_full;
  assign o_Overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_msg_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_msg_buffer
//   Scoreboard bench for uart_rx_msg_buffer (DEPTH = 16, TERMINATOR = 8'h0A).
//   Accepted bytes are pushed to an expected queue; each pop compares the
//   DUT head byte against the queue front.
// -----------------------------------------------------------------------------
module tb_uart_rx_msg_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam logic [7:0]  TERM  = 8'h0A;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          rd_en;
  logic          clr_ovf;
  logic          byte_valid;
  logic [7:0]    head_byte;
  logic          last;
  logic [LW-1:0] level;
  logic [LW-1:0] msg_count;
  logic          full;
  logic          overflow;

  uart_rx_msg_buffer #(
    .DEPTH      (DEPTH),
    .TERMINATOR (TERM)
  ) dut (
    .i_Clock          (clk),
    .i_Reset_N        (rst_n),
    .i_Rx_DV          (rx_dv),
    .i_Rx_Byte        (rx_byte),
    .i_Rd_En          (rd_en),
    .i_Clear_Overflow (clr_ovf),
    .o_Byte_Valid     (byte_valid),
    .o_Byte           (head_byte),
    .o_Last           (last),
    .o_Level          (level),
    .o_Msg_Count      (msg_count),
    .o_Full           (full),
    .o_Overflow       (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] exp_q [$];
  logic       m_ovf;
  logic       m_discard;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int unsigned model_msgs();
    int unsigned n = 0;
    foreach (exp_q[i]) if (exp_q[i] == TERM) n++;
    return n;
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".level"}, 32'(level), exp_q.size());
    check({tag, ".msgs"},  32'(msg_count), model_msgs());
    check({tag, ".valid"}, 32'(byte_valid), (exp_q.size() != 0) ? 1 : 0);
    check({tag, ".full"},  32'(full), (exp_q.size() == DEPTH) ? 1 : 0);
    check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    if (exp_q.size() != 0) begin
      check({tag, ".head"}, 32'(head_byte), 32'(exp_q[0]));
      check({tag, ".last"}, 32'(last), (exp_q[0] == TERM) ? 1 : 0);
    end else begin
      check({tag, ".last"}, 32'(last), 0);
    end
  endtask

  // One clock of stimulus, entered and left on a falling edge.
  task automatic cycle(input string tag, input logic dv, input logic [7:0] b,
                       input logic rd, input logic clr);
    logic full_now, pop_now, push_now, ovf_ev;
    rx_dv   = dv;
    rx_byte = b;
    rd_en   = rd;
    clr_ovf = clr;
    full_now = (exp_q.size() == DEPTH);
    pop_now  = rd && (exp_q.size() != 0);
    push_now = 1'b0;
    ovf_ev   = 1'b0;
    if (dv) begin
      if (!m_discard) begin
        if (!full_now) push_now = 1'b1;
        else begin
          ovf_ev = 1'b1;
          if (b != TERM) m_discard = 1'b1;
        end
      end else if (full_now) begin
        ovf_ev = 1'b1;
      end else if (b == TERM) begin
        push_now  = 1'b1;
        m_discard = 1'b0;
      end
    end
    if (pop_now) check({tag, ".pop_byte"}, 32'(head_byte), 32'(exp_q[0]));
    @(posedge clk);
    if (pop_now)  void'(exp_q.pop_front());
    if (push_now) exp_q.push_back(b);
    if (ovf_ev)   m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clk);
    rx_dv   = 1'b0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    check_status(tag);
  endtask

  task automatic wr(input string tag, input logic [7:0] b);
    cycle(tag, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag);
    cycle(tag, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) rd(tag);
  endtask

  // One-cycle reset with a write strobe that must be ignored.
  task automatic pulse_reset(input string tag);
    rst_n   = 1'b0;
    rx_dv   = 1'b1;
    rx_byte = 8'h58;
    @(posedge clk);
    exp_q.delete();
    m_ovf     = 1'b0;
    m_discard = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx_dv = 1'b0;
    check({tag, ".level"}, 32'(level), 0);
    check({tag, ".msgs"},  32'(msg_count), 0);
    check({tag, ".valid"}, 32'(byte_valid), 0);
    check({tag, ".full"},  32'(full), 0);
    check({tag, ".last"},  32'(last), 0);
    check({tag, ".ovf"},   32'(overflow), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    rd_en     = 1'b0;
    clr_ovf   = 1'b0;
    m_ovf     = 1'b0;
    m_discard = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_status("reset");

    // "AB\n" then three pops
    wr("ab", 8'h41);
    wr("ab", 8'h42);
    wr("ab", TERM);
    check("ab.level3", 32'(level), 3);
    check("ab.msg1",   32'(msg_count), 1);
    check("ab.head41", 32'(head_byte), 32'h41);
    check("ab.last0",  32'(last), 0);
    rd("ab_pop1");
    rd("ab_pop2");
    check("ab.last_on_term", 32'(last), 1);
    rd("ab_pop3");
    check("ab.msg0",   32'(msg_count), 0);
    check("ab.empty",  32'(byte_valid), 0);

    // Fill, overflow mid-message, close the truncated message
    for (int i = 0; i < 16; i++) wr("fill", 8'h55);
    wr("ovf66", 8'h66);
    wr("ovf0a", TERM);
    check("fill.full", 32'(full), 1);
    check("fill.ovf",  32'(overflow), 1);
    check("fill.msg0", 32'(msg_count), 0);
    rd("fill_pop");
    wr("disc77", 8'h77);
    check("disc77.dropped", 32'(level), 15);
    wr("disc0a", TERM);
    check("disc0a.stored", 32'(level), 16);
    check("disc0a.msg1",   32'(msg_count), 1);
    rd("accept_pop");
    wr("accept_wr", 8'h12);
    check("accept.stored", 32'(level), 16);
    drain("fill_drain");
    cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr.ovf0", 32'(overflow), 0);

    // Level 5 with terminator at the head: write TERM and pop TERM together
    wr("l5", TERM);
    for (int i = 0; i < 4; i++) wr("l5", 8'h30 + 8'(i));
    cycle("l5_both", 1'b1, TERM, 1'b1, 1'b0);
    check("l5.level", 32'(level), 5);
    check("l5.msgs",  32'(msg_count), 1);
    drain("l5_drain");

    // Full: simultaneous write and pop, write rejected
    for (int i = 0; i < 16; i++) wr("full", 8'h60 + 8'(i));
    cycle("full_both", 1'b1, 8'h21, 1'b1, 1'b0);
    check("full_both.level", 32'(level), 15);
    check("full_both.ovf",   32'(overflow), 1);
    wr("full_close", TERM);
    wr("refill", 8'h22);
    // Overflow event and clear in the same cycle: event wins
    cycle("clr_vs_ovf", 1'b1, 8'h23, 1'b0, 1'b1);
    check("clr_vs_ovf.ovf", 32'(overflow), 1);
    drain("full_drain");
    cycle("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
    // Still in DISCARD after the last drop; close it so later phases start clean
    wr("reclose", TERM);
    drain("reclose_drain");

    // Read strobe on an empty buffer
    for (int i = 0; i < 10; i++) rd("rd_empty");
    check("rd_empty.level", 32'(level), 0);
    wr("after_empty", 8'h5A);
    check("after_empty.head", 32'(head_byte), 32'h5A);
    drain("after_empty_drain");

    // Reset while 3 bytes stored and in DISCARD
    for (int i = 0; i < 16; i++) wr("pre_rst", 8'h40 + 8'(i));
    wr("pre_rst_ovf", 8'h33);
    for (int i = 0; i < 13; i++) rd("pre_rst_pop");
    check("pre_rst.level3", 32'(level), 3);
    pulse_reset("rst");
    wr("x", 8'h58);
    wr("x", TERM);
    check("x.level", 32'(level), 2);
    check("x.msgs",  32'(msg_count), 1);
    drain("x_drain");

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 4) == 0) ? TERM : 8'($urandom_range(32, 126));
      cycle("rand", ($urandom_range(0, 2) != 0), b,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
